// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ID-stage pipeline controller.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned CNT_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LUI  = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BR   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_HALT = 7'b0000000;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       jal_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       branch;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pipe_state_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: control bundle, source-register usage, halt/illegal classification.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit HALT_EN = 1'b1
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        bundle,
  output logic                rs1_used,
  output logic                rs2_used,
  output logic                is_halt,
  output logic                is_illegal
);

  // Opcode class lookup; anything unrecognised yields a bubble and is flagged.
  always_comb begin
    bundle     = CTRL_BUBBLE;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        bundle.reg_write = 1'b1;
        bundle.alu_op    = 2'b10;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_I: begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = 2'b10;
        rs1_used         = 1'b1;
      end
      OP_LUI: begin
        bundle.alu_src   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_op    = 2'b11;
      end
      OP_LW: begin
        bundle.alu_src    = 1'b1;
        bundle.mem_to_reg = 1'b1;
        bundle.mem_read   = 1'b1;
        bundle.reg_write  = 1'b1;
        rs1_used          = 1'b1;
      end
      OP_SW: begin
        bundle.alu_src   = 1'b1;
        bundle.mem_write = 1'b1;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_BR: begin
        bundle.branch = 1'b1;
        bundle.alu_op = 2'b01;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OP_JAL: begin
        bundle.jal_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
      end
      OP_JALR: begin
        bundle.jal_to_reg = 1'b1;
        bundle.reg_write  = 1'b1;
        rs1_used          = 1'b1;
      end
      OP_HALT: begin
        is_halt    = HALT_EN;
        is_illegal = ~HALT_EN;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage pipeline controller: decode, ID/EX control register, stall/flush/halt sequencing.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned FLUSH_SLOTS     = 2,
  parameter bit          HALT_EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_redirect,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_jal_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  halted,
  output logic                  illegal
);

  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_SLOTS - 1);

  pipe_state_t           state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  ctrl_bundle_t          ex_q, ex_nx;
  logic [REG_ADDR_W-1:0] rd_q, rd_nx;
  logic                  illegal_q, illegal_nx;

  ctrl_bundle_t dec_bundle;
  logic         rs1_used, rs2_used, is_halt, is_illegal;
  logic         hazard;

  ctrl_decoder #(.HALT_EN(HALT_EN)) u_dec (
    .opcode     (id_opcode),
    .bundle     (dec_bundle),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Load in EX feeding a source register actually read by the ID instruction.
  assign hazard = id_valid & ex_q.mem_read & (rd_q != '0) &
                  ((rs1_used & (rd_q == id_rs1)) | (rs2_used & (rd_q == id_rs2)));

  // State, counter, ID/EX bundle and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      ex_q      <= CTRL_BUBBLE;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ex_q      <= ex_nx;
      rd_q      <= rd_nx;
      illegal_q <= illegal_nx;
    end
  end

  // Next-state, ID/EX input selection and PC/IF-ID enables; priority redirect > hazard > halt > illegal.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ex_nx         = CTRL_BUBBLE;
    rd_nx         = '0;
    illegal_nx    = illegal_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    case (state)
      RUN: begin
        if (ex_redirect) begin
          state_nx   = FLUSH;
          cnt_nx     = FLUSH_LOAD;
          ifid_flush = 1'b1;
        end else if (hazard) begin
          state_nx      = STALL;
          cnt_nx        = STALL_LOAD;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end else if (id_valid && is_halt) begin
          state_nx      = HALT;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end else if (id_valid && is_illegal) begin
          illegal_nx = 1'b1;
        end else if (id_valid) begin
          ex_nx = dec_bundle;
          rd_nx = id_rd;
        end
      end
      STALL: begin
        if (ex_redirect) begin
          state_nx   = FLUSH;
          cnt_nx     = FLUSH_LOAD;
          ifid_flush = 1'b1;
        end else begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          if (cnt == '0) state_nx = RUN;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        if (ex_redirect)      cnt_nx   = FLUSH_LOAD;
        else if (cnt == '0)   state_nx = RUN;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      HALT: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
      end
      default: state_nx = RUN;
    endcase
  end

  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_jal_to_reg = ex_q.jal_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rd         = rd_q;
  assign halted        = (state == HALT);
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (LOAD_USE_STALLS=2, FLUSH_SLOTS=2, HALT_EN=1).
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect;
  logic       ex_alu_src, ex_mem_to_reg, ex_jal_to_reg, ex_reg_write;
  logic       ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rd;
  logic       pc_write_en, ifid_write_en, ifid_flush, halted, illegal;
  logic [8:0] ex_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected bundles {alu_src,mem_to_reg,jal_to_reg,reg_write,mem_read,mem_write,alu_op,branch}
  localparam logic [8:0] B_NOP = 9'b000000000;
  localparam logic [8:0] B_R   = 9'b000100100;
  localparam logic [8:0] B_LW  = 9'b110110000;
  localparam logic [8:0] B_LUI = 9'b100100110;
  localparam logic [8:0] B_SW  = 9'b100001000;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  pipe_ctrl_unit #(
    .REG_ADDR_W(5), .LOAD_USE_STALLS(2), .FLUSH_SLOTS(2), .HALT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_jal_to_reg(ex_jal_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .halted(halted), .illegal(illegal)
  );

  assign ex_vec = {ex_alu_src, ex_mem_to_reg, ex_jal_to_reg, ex_reg_write,
                   ex_mem_read, ex_mem_write, ex_alu_op, ex_branch};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd, input logic redir);
    id_valid    = v;
    id_opcode   = op;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    ex_redirect = redir;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [8:0] vec, input logic [4:0] rd);
    check({tag, "_bundle"}, 32'(ex_vec), 32'(vec));
    check({tag, "_rd"}, 32'(ex_rd), 32'(rd));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk_ex("rst_ex", B_NOP, 5'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc_we", 32'(pc_write_en), 32'd1);
    check("rst_ifid_we", 32'(ifid_write_en), 32'd1);
    check("rst_flush", 32'(ifid_flush), 32'd0);

    // R-type decoded one cycle later
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    check("r_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk_ex("r_ex", B_R, 5'd3);

    // Load-use on rs1: hazard cycle plus two STALL cycles hold the front end
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    chk_ex("lw_ex", B_LW, 5'd5);
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b0);
    check("lu_hz_pc_we", 32'(pc_write_en), 32'd0);
    check("lu_hz_ifid_we", 32'(ifid_write_en), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_ex("lu_bubble", B_NOP, 5'd0);
      check("lu_stall_pc_we", 32'(pc_write_en), 32'd0);
    end
    tick();
    chk_ex("lu_bubble_last", B_NOP, 5'd0);
    check("lu_resume_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk_ex("lu_add_ex", B_R, 5'd7);

    // Load into x0 never stalls
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drv(1'b1, OP_R, 5'd0, 5'd0, 5'd4, 1'b0);
    check("x0_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk_ex("x0_ex", B_R, 5'd4);

    // LUI does not read rs1, even when the field matches the load destination
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd9, 1'b0);
    tick();
    drv(1'b1, OP_LUI, 5'd9, 5'd9, 5'd9, 1'b0);
    check("lui_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk_ex("lui_ex", B_LUI, 5'd9);

    // Store reading the load result on rs2 stalls
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd9, 1'b0);
    tick();
    drv(1'b1, OP_SW, 5'd0, 5'd9, 5'd0, 1'b0);
    check("sw_hz_pc_we", 32'(pc_write_en), 32'd0);
    tick();
    tick();
    tick();
    check("sw_resume_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    chk_ex("sw_ex", B_SW, 5'd0);

    // Redirect pulse: flush on the redirect cycle plus two FLUSH cycles
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b1);
    check("rd_flush0", 32'(ifid_flush), 32'd1);
    check("rd_pc_we0", 32'(pc_write_en), 32'd1);
    tick();
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk_ex("rd_bubble", B_NOP, 5'd0);
      check("rd_flush", 32'(ifid_flush), 32'd1);
      tick();
    end
    check("rd_run_flush", 32'(ifid_flush), 32'd0);
    tick();
    chk_ex("rd_after_ex", B_R, 5'd3);

    // Redirect coincident with a hazard goes to FLUSH
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b1);
    check("rdhz_flush", 32'(ifid_flush), 32'd1);
    check("rdhz_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b0);
    check("rdhz_flush1", 32'(ifid_flush), 32'd1);
    tick();
    check("rdhz_flush2", 32'(ifid_flush), 32'd1);
    tick();
    check("rdhz_run_pc_we", 32'(pc_write_en), 32'd1);
    check("rdhz_run_flush", 32'(ifid_flush), 32'd0);
    tick();

    // Redirect during STALL preempts it
    drv(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b0);
    tick();
    check("strd_stall_pc_we", 32'(pc_write_en), 32'd0);
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b1);
    check("strd_flush", 32'(ifid_flush), 32'd1);
    check("strd_pc_we", 32'(pc_write_en), 32'd1);
    tick();
    drv(1'b1, OP_R, 5'd5, 5'd6, 5'd7, 1'b0);
    tick();
    tick();
    check("strd_run_flush", 32'(ifid_flush), 32'd0);

    // Reset mid-FLUSH
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    do_reset();
    check("rstfl_flush", 32'(ifid_flush), 32'd0);
    check("rstfl_pc_we", 32'(pc_write_en), 32'd1);
    chk_ex("rstfl_ex", B_NOP, 5'd0);

    // Illegal opcode: sticky flag, bubble, pipeline keeps advancing
    drv(1'b1, 7'b1111111, 5'd1, 5'd2, 5'd3, 1'b0);
    check("ill_pc_we", 32'(pc_write_en), 32'd1);
    check("ill_ifid_we", 32'(ifid_write_en), 32'd1);
    tick();
    check("ill_flag", 32'(illegal), 32'd1);
    chk_ex("ill_ex", B_NOP, 5'd0);
    drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    check("ill_sticky", 32'(illegal), 32'd1);
    chk_ex("ill_next_ex", B_R, 5'd3);
    do_reset();
    check("ill_cleared", 32'(illegal), 32'd0);

    // HALT: sticky across redirects, cleared only by reset
    drv(1'b1, 7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0);
    check("halt_pc_we0", 32'(pc_write_en), 32'd0);
    tick();
    check("halt_set", 32'(halted), 32'd1);
    chk_ex("halt_ex", B_NOP, 5'd0);
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b1);
      check("halt_pc_we", 32'(pc_write_en), 32'd0);
      check("halt_flush", 32'(ifid_flush), 32'd0);
      tick();
      check("halt_hold", 32'(halted), 32'd1);
      check("halt_bubble", 32'(ex_vec), 32'(B_NOP));
    end
    do_reset();
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_rst_pc_we", 32'(pc_write_en), 32'd1);
    check("halt_rst_illegal", 32'(illegal), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
